// File: rtl/cache_request_arbiter_if.sv
// Client-side and memory-side signals of the cache request arbiter.
// The slave modport is the arbiter's view; master is the clients plus memory.
interface cache_request_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int GW = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            port_read_request;
    logic [NUM_PORTS-1:0]            port_write_request;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] port_write_data;
    logic [NUM_PORTS-1:0]            port_response;
    logic [DATA_WIDTH-1:0]           port_read_data;
    logic                            port_error;
    logic [GW-1:0]                   grant_id;
    logic                            busy;
    logic                            memory_read_request;
    logic                            memory_write_request;
    logic [ADDR_WIDTH-1:0]           memory_addr;
    logic [DATA_WIDTH-1:0]           memory_write_data;
    logic                            memory_response;
    logic [DATA_WIDTH-1:0]           memory_read_data;

    modport slave (
        input  port_read_request, port_write_request, port_address, port_write_data,
               memory_response, memory_read_data,
        output port_response, port_read_data, port_error, grant_id, busy,
               memory_read_request, memory_write_request, memory_addr, memory_write_data
    );

    modport master (
        output port_read_request, port_write_request, port_address, port_write_data,
               memory_response, memory_read_data,
        input  port_response, port_read_data, port_error, grant_id, busy,
               memory_read_request, memory_write_request, memory_addr, memory_write_data
    );
endinterface

// File: rtl/cache_request_arbiter.sv
// N-port cache request arbiter: one outstanding memory transaction, fixed
// priority or round-robin grant, optional response timeout with error flag.
module cache_request_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    cache_request_arbiter_if.slave bus
);
    localparam int GW      = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW      = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t               state;
    logic [TW-1:0]        to_cnt;
    logic [NUM_PORTS-1:0] eligible;
    logic                 any_eligible;
    logic [GW-1:0]        winner;

    assign eligible     = bus.port_read_request | bus.port_write_request;
    assign any_eligible = |eligible;
    assign bus.busy     = (state != IDLE);

    generate
        if (ARB_MODE == 0) begin : g_fixed
            // Later (higher) indices overwrite earlier ones, so the top eligible port wins.
            always_comb begin
                winner = '0;
                for (int i = 0; i < NUM_PORTS; i++)
                    if (eligible[i]) winner = GW'(i);
            end
        end else begin : g_rr
            // grant_id doubles as the round-robin pointer: it only moves on a grant.
            logic [GW-1:0] idx;
            logic          found;
            always_comb begin
                winner = '0;
                found  = 1'b0;
                idx    = bus.grant_id;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = (idx == GW'(NUM_PORTS - 1)) ? '0 : idx + GW'(1);
                    if (!found && eligible[idx]) begin
                        winner = idx;
                        found  = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= IDLE;
            to_cnt                   <= '0;
            bus.grant_id             <= '0;
            bus.port_response        <= '0;
            bus.port_read_data       <= '0;
            bus.port_error           <= 1'b0;
            bus.memory_read_request  <= 1'b0;
            bus.memory_write_request <= 1'b0;
            bus.memory_addr          <= '0;
            bus.memory_write_data    <= '0;
        end else begin
            bus.port_response <= '0;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        bus.grant_id             <= winner;
                        bus.memory_addr          <= bus.port_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.memory_write_data    <= bus.port_write_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        // A port raising both read and write is treated as a write.
                        bus.memory_write_request <= bus.port_write_request[winner];
                        bus.memory_read_request  <= !bus.port_write_request[winner];
                        to_cnt                   <= '0;
                        state                    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.memory_response) begin
                        bus.memory_read_request        <= 1'b0;
                        bus.memory_write_request       <= 1'b0;
                        bus.port_read_data             <= bus.memory_read_data;
                        bus.port_error                 <= 1'b0;
                        bus.port_response[bus.grant_id] <= 1'b1;
                        state                          <= RESP;
                    end else if (TIMEOUT_CYCLES > 0 && to_cnt == TW'(TO_LAST)) begin
                        bus.memory_read_request        <= 1'b0;
                        bus.memory_write_request       <= 1'b0;
                        bus.port_read_data             <= '0;
                        bus.port_error                 <= 1'b1;
                        bus.port_response[bus.grant_id] <= 1'b1;
                        state                          <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_request_arbiter.md
Name: cache_request_arbiter

Overview:
- N-port successor to the two-port cache request multiplexer.
- Arbitrates read/write requests from NUM_PORTS cache clients onto one memory interface, with one transaction outstanding at a time.
- Arbitration is selectable between fixed priority and round robin.
- An optional response timeout completes a stalled access with an error flag.
- Sits between the I/D caches (plus future clients such as DMA or a page walker) and the memory/bus bridge.

Parameters:
- NUM_PORTS, 2, number of client ports (>=2).
- DATA_WIDTH, 32, data width.
- ADDR_WIDTH, 32, address width.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round robin.
- TIMEOUT_CYCLES, 0, memory response timeout in cycles; 0 disables the timeout.
- Derived localparam GW = max(1, $clog2(NUM_PORTS)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- port_read_request  in  NUM_PORTS  per-port read request, held until the matching port_response.
- port_write_request  in  NUM_PORTS  per-port write request, same hold rule.
- port_address  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- port_write_data  in  NUM_PORTS*DATA_WIDTH  packed write data.
- port_response  out  NUM_PORTS  one-cycle completion pulse per port.
- port_read_data  out  DATA_WIDTH  shared read data, valid with port_response.
- port_error  out  1  completion was a timeout; valid with port_response.
- grant_id  out  GW  index of the port currently or most recently served.
- busy  out  1  transaction in progress (state != IDLE).
- memory_read_request  out  1  registered read request to memory.
- memory_write_request  out  1  registered write request to memory.
- memory_addr  out  ADDR_WIDTH  registered address.
- memory_write_data  out  DATA_WIDTH  registered write data.
- memory_response  in  1  memory completion, single-cycle pulse.
- memory_read_data  in  DATA_WIDTH  memory read data, valid with memory_response.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs are 0, the state is IDLE, the round-robin pointer is 0 and the timeout counter is 0. Reset mid-transaction aborts the transaction silently and issues no port_response.
- State machine has three states: IDLE, ISSUE, RESP.
- IDLE:
  - A port is eligible when its read request or write request is high.
  - If any port is eligible, choose a winner, then on the clock edge latch its address and write data and go to ISSUE.
  - If the winner has the write request high, set memory_write_request=1; otherwise set memory_read_request=1.
  - If a port asserts both read and write, the write wins and the read is ignored.
  - Update grant_id to the winner.
- Fixed priority arbitration: the highest-index eligible port wins.
- Round-robin arbitration: search starts at (last grant + 1) mod NUM_PORTS and wraps around. The pointer updates only on a grant.
- ISSUE:
  - Memory request, address and write data stay stable until memory_response.
  - On memory_response: clear both memory requests, capture memory_read_data into port_read_data, set port_error=0 and go to RESP.
  - Port requests that change during ISSUE are ignored.
- Timeout (TIMEOUT_CYCLES>0 only):
  - A counter clears on entry to ISSUE and increments each cycle spent in ISSUE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no memory_response, clear the memory requests, set port_read_data=0 and port_error=1, then go to RESP.
  - If memory_response arrives in the same cycle as the timeout, it takes precedence and is a normal completion.
- RESP:
  - port_response[grant_id]=1 for exactly one cycle, and no grant is made in this cycle.
  - Next state is IDLE.
  - A client drops its request on the edge that ends its port_response cycle, so it is not re-granted.
- Memory_response arriving in IDLE or RESP is ignored.
- Latency:
  - Request visible in cycle N leads to a memory request asserted in cycle N+1.
  - memory_response in cycle M leads to port_response in cycle M+1.
  - Minimum turnaround is 3 cycles per transaction.
- port_read_data and port_error hold their values until the next completion.
- After reset, before any grant, grant_id reads 0.

Test Plan:
- Single read, ARB_MODE=0: port0 read at 0x100, memory responds 2 cycles later with 0xDEADBEEF -> memory_read_request high for 2 cycles, addr 0x100; port_response=2'b01 one cycle after memory_response; port_read_data=0xDEADBEEF; port_error=0.
- Fixed priority, NUM_PORTS=2: port0 read and port1 write (addr 0x200, data 0x12345678) asserted in the same cycle -> port1 is served first with memory_write_request and data 0x12345678; port0 is granted in the IDLE cycle after port1's RESP.
- Round robin, NUM_PORTS=4: ports 0-3 request continuously -> grant order 1,2,3,0,1 with one response pulse each and no port starved.
- Read+write on the same port (port0, addr 0x40) -> only memory_write_request is asserted; one port_response.
- Timeout, TIMEOUT_CYCLES=8: memory never responds -> requests drop after 8 ISSUE cycles; port_response with port_error=1 and port_read_data=0; a later normal access has port_error=0.
- Reset mid-ISSUE: pull rst_n low asynchronously (off clock edge) -> memory requests drop immediately and no port_response is issued; after release, a pending request is re-arbitrated with the round-robin pointer at 0.
